// File: rtl/pwm4_pkg.sv
// rtl/pwm4_pkg.sv - shared types and constants for the 2-bit symbol framer
// Optional feature macro: FRAMER_CHECKSUM_EN (adds the CHECK state).
package pwm4_pkg;

  localparam int          SYM_W         = 2;
  localparam int          SYMS_PER_BYTE = 4;
  localparam logic [7:0]  DEFAULT_SYNC  = 8'hCC;

`ifdef FRAMER_CHECKSUM_EN
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;
`else
  typedef enum logic [1:0] {HUNT, PAYLOAD} state_t;
`endif

endpackage

// File: rtl/sym_fifo.sv
// rtl/sym_fifo.sv - first-word-fall-through byte FIFO; push on full succeeds only alongside a pop
module sym_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so byte_out is 0 out of reset.
  assign dout    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/symbol_framer.sv
// rtl/symbol_framer.sv - hunts a 2-bit-symbol sync word, packs payload into bytes, buffers them
// Optional feature macro: FRAMER_CHECKSUM_EN (XOR check byte after the payload).
module symbol_framer
  import pwm4_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD     = DEFAULT_SYNC,
  parameter int         PAYLOAD_BYTES = 4,
  parameter int         FIFO_DEPTH    = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sym_valid,
  input  logic signed [7:0] decoded_symbol,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              frame_start,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              sym_error,
  output logic              overflow
);

  state_t           state, state_n;
  logic [5:0]       window;
  logic [5:0]       byte_acc;
  logic [1:0]       sym_cnt;
  logic [7:0]       byte_cnt;
  logic [SYM_W-1:0] sym;
  logic             sym_legal;
  logic [7:0]       win_next;
  logic [7:0]       byte_next;
  logic             last_sym;
  logic             last_byte;
  logic             push;
  logic             start_n, done_n, ok_n, err_n;
  logic             fifo_full, fifo_empty;
`ifdef FRAMER_CHECKSUM_EN
  logic [7:0]       xor_acc;
`endif

  assign sym       = decoded_symbol[SYM_W-1:0];
  assign sym_legal = (decoded_symbol[7:SYM_W] == '0);
  assign win_next  = {window, sym};
  assign byte_next = {byte_acc, sym};
  assign last_sym  = (sym_cnt == 2'(SYMS_PER_BYTE - 1));
  assign last_byte = (byte_cnt == 8'(PAYLOAD_BYTES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= HUNT;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    push    = 1'b0;
    start_n = 1'b0;
    done_n  = 1'b0;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    if (sym_valid) begin
      if (!sym_legal) begin
        err_n   = 1'b1;
        state_n = HUNT;
      end else begin
        case (state)
          HUNT: if (win_next == SYNC_WORD) begin
            state_n = PAYLOAD;
            start_n = 1'b1;
          end
          PAYLOAD: if (last_sym) begin
            push = 1'b1;
            if (last_byte) begin
`ifdef FRAMER_CHECKSUM_EN
              state_n = CHECK;
`else
              state_n = HUNT;
              done_n  = 1'b1;
              ok_n    = 1'b1;
`endif
            end
          end
`ifdef FRAMER_CHECKSUM_EN
          CHECK: if (last_sym) begin
            state_n = HUNT;
            done_n  = 1'b1;
            ok_n    = (byte_next == xor_acc);
          end
`endif
          default: state_n = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      window      <= '0;
      byte_acc    <= '0;
      sym_cnt     <= '0;
      byte_cnt    <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      sym_error   <= 1'b0;
      overflow    <= 1'b0;
`ifdef FRAMER_CHECKSUM_EN
      xor_acc     <= '0;
`endif
    end else begin
      frame_start <= start_n;
      frame_done  <= done_n;
      frame_ok    <= ok_n;
      sym_error   <= err_n;
      if (push && fifo_full && !byte_ready) overflow <= 1'b1;
      if (sym_valid) begin
        if (!sym_legal) begin
          window  <= '0;
          sym_cnt <= '0;
        end else begin
          case (state)
            HUNT: begin
              // The sync match clears the window so PAYLOAD starts from a clean slate.
              window   <= (state_n == PAYLOAD) ? 6'd0 : win_next[5:0];
              sym_cnt  <= '0;
              byte_cnt <= '0;
`ifdef FRAMER_CHECKSUM_EN
              xor_acc  <= '0;
`endif
            end
            default: begin
              byte_acc <= byte_next[5:0];
              sym_cnt  <= sym_cnt + 2'd1;
              if (last_sym && state == PAYLOAD) begin
                byte_cnt <= byte_cnt + 8'd1;
`ifdef FRAMER_CHECKSUM_EN
                xor_acc  <= xor_acc ^ byte_next;
`endif
              end
            end
          endcase
        end
      end
    end
  end

  sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (byte_ready),
    .din     (byte_next),
    .dout    (byte_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign byte_valid = !fifo_empty;

endmodule

// File: doc/symbol_framer.md
SYMBOL_FRAMER -- requirements
Module: symbol_framer

Interface
REQ-001 Parameter SYNC_WORD, default 8'hCC: four 2-bit symbols, MSB pair first (3,0,3,0), marking a frame start.
REQ-002 Parameter PAYLOAD_BYTES, default 4: payload bytes per frame, legal range 1..255.
REQ-003 Parameter FIFO_DEPTH, default 4: output byte buffer depth, power of two, at least 2.
REQ-004 Port: clock, input, 1, the single clock; all logic on its rising edge.
REQ-005 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port: sym_valid, input, 1, decoded_symbol is valid in this cycle.
REQ-007 Port: decoded_symbol, input, 8 signed, symbol from the decoder stage; legal values 0..3.
REQ-008 Port: byte_out, output, 8, FIFO head byte.
REQ-009 Port: byte_valid, output, 1, byte_out is valid (FIFO not empty).
REQ-010 Port: byte_ready, input, 1, consumer accepts the head when byte_valid and byte_ready are both high.
REQ-011 Port: frame_start / frame_done / frame_ok / sym_error, outputs, 1 each, single-cycle status pulses.
REQ-012 Port: overflow, output, 1, sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-013 States: HUNT, PAYLOAD, CHECK (CHECK exists only with FRAMER_CHECKSUM_EN).
- Symbols are consumed only in cycles with sym_valid=1.
REQ-014 HUNT: shift each legal symbol into a 4-symbol window (8 bits, newest in the LSBs).
- When the window equals SYNC_WORD: go to PAYLOAD and pulse frame_start in the next cycle.
- Clear the window and the symbol counter on entry to PAYLOAD.
REQ-015 PAYLOAD: pack 4 symbols per byte, first symbol into bits [7:6].
- After the 4th symbol, push the byte to the FIFO; byte_valid goes high in the following cycle if the FIFO was empty.
REQ-016 After PAYLOAD_BYTES pushes: go to CHECK if FRAMER_CHECKSUM_EN is defined, else return to HUNT and pulse frame_done with frame_ok=1.
REQ-017 Illegal symbol (sym_valid=1 and value outside 0..3):
- Pulse sym_error.
- In HUNT: clear the window.
- In PAYLOAD or CHECK: discard the partial byte and return to HUNT; no frame_done.
- Bytes already pushed remain in the FIFO.
REQ-018 FIFO is first-word-fall-through.
- Push on full with no pop in the same cycle: drop the byte and set overflow.
- Push on full with a pop in the same cycle: the push succeeds.
- Pop on empty: ignored.
REQ-019 byte_out is held stable while byte_valid=1 and byte_ready=0.

Reset
REQ-020 While reset_n=0:
- State is HUNT; window, counters and FIFO pointers are cleared.
- byte_out=0, byte_valid=0 and all pulses are 0; overflow is cleared.
REQ-021 Reset asserted mid-frame aborts the frame with no status pulse.
- Outputs go to reset values immediately (asynchronously).
- Operation resumes on the first rising edge after reset_n goes high.

Configuration
REQ-022 Macro FRAMER_CHECKSUM_EN, when defined:
- After the payload, 4 more symbols form a check byte; CHECK collects them.
- The check byte is compared with the XOR of all payload bytes of the frame.
- The check byte is not pushed to the FIFO.
- After the comparison, pulse frame_done with frame_ok = (match), then return to HUNT.
REQ-023 Macro FRAMER_CHECKSUM_EN, when not defined:
- No CHECK state and no XOR accumulator.
- frame_ok=1 whenever frame_done pulses.

Structure
REQ-024 Shared package pwm4_pkg holds:
- The state enum.
- SYM_W=2 and SYMS_PER_BYTE=4.
- The default sync word constant.
REQ-025 The FIFO is sub-module sym_fifo (parameter DEPTH; ports clock, reset_n, push, pop, din, dout, full, empty).

Verification
REQ-026 Symbols 3,0,3,0 then 1,2,3,0, PAYLOAD_BYTES=1, checksum off -> frame_start pulse, byte_out=8'h6C with byte_valid, then frame_done with frame_ok=1.
REQ-027 Checksum on, sync, payload 8'h6C,8'h01,8'hFF,8'h00, check 8'h92 -> frame_ok=1; the same frame with check 8'h93 -> frame_ok=0, and only 4 bytes appear in the FIFO.
REQ-028 Sync, symbols 1,2 then symbol value -1 -> sym_error pulse, return to HUNT, no byte pushed, no frame_done.
REQ-029 byte_ready held 0, FIFO_DEPTH=4, PAYLOAD_BYTES=6 -> 4 bytes held and overflow=1; then byte_ready=1 -> those 4 bytes drain in order.
REQ-030 reset_n pulsed low mid-PAYLOAD -> byte_valid=0 and overflow=0 immediately; the next sync is detected normally afterwards.
REQ-031 Window sequence 3,0,3,3,0,3,0 -> exactly one frame_start, after the 7th symbol.
